sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_wait_counter.sv | 24 ++
 rtl/sram_controller.sv | 130 +++++++++++++
 tb/tb_sram_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding and SRAM geometry for the SRAM controller
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable down-counter pacing idle SRAM cycles after each access
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port onto a 16-bit async SRAM as two half-word cycles
// Optional range check with addr_err output when SRAM_CTRL_ADDR_ERR_EN is defined.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
`ifdef SRAM_CTRL_ADDR_ERR_EN
  output logic                   addr_err,
`endif
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  state_t                 state;
  logic                   req;
  logic                   req_err;
  logic [18:0]            offset;
  logic [SRAM_ADDR_W-2:0] idx_in;
  logic                   cur_wr;
  logic                   cur_err;
  logic [SRAM_ADDR_W-2:0] cur_idx;
  logic [31:0]            cur_data;
  logic [15:0]            rd_lo;
  logic                   dq_oe;
  logic [15:0]            dq_out;
  logic [3:0]             wait_count;
  logic                   wait_zero;
  logic                   unused_bits;

  assign req         = wr_en | rd_en;
  assign offset      = address[18:0] - BASE_ADDR[18:0];
  assign idx_in      = offset[18:2];
  assign unused_bits = ^{offset[1:0], address[31:19], wait_count};

`ifdef SRAM_CTRL_ADDR_ERR_EN
  logic [32:0] addr_ext;
  assign addr_ext = {1'b0, address};
  assign req_err  = (addr_ext < {1'b0, BASE_ADDR}) ||
                    (addr_ext >= ({1'b0, BASE_ADDR} + 33'h80000));
  assign addr_err = (state == DONE) && cur_err;
`else
  assign req_err = 1'b0;
`endif

  sram_wait_counter u_wait (
    .clk       (clk),
    .rst       (rst),
    .load      (state == HI),
    .dec       (state == WAIT),
    .load_value(4'(WAIT_CYCLES - 1)),
    .count     (wait_count),
    .zero      (wait_zero)
  );

  // Low half is parked in rd_lo so read_data only changes once the whole word is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_wr    <= 1'b0;
      cur_err   <= 1'b0;
      cur_idx   <= '0;
      cur_data  <= 32'd0;
      rd_lo     <= 16'd0;
      read_data <= 32'd0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= LO;
            cur_wr    <= wr_en;
            cur_err   <= req_err;
            cur_idx   <= idx_in;
            cur_data  <= write_data;
            SRAM_ADDR <= {idx_in, 1'b0};
            SRAM_WE_N <= !(wr_en && !req_err);
            dq_oe     <= wr_en && !req_err;
            dq_out    <= write_data[15:0];
          end
        end
        LO: begin
          state     <= HI;
          SRAM_ADDR <= {cur_idx, 1'b1};
          dq_out    <= cur_data[31:16];
          rd_lo     <= SRAM_DQ;
        end
        HI: begin
          state     <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          SRAM_ADDR <= '0;
          SRAM_WE_N <= 1'b1;
          dq_oe     <= 1'b0;
          if (!cur_wr) begin
            read_data <= cur_err ? 32'd0 : {SRAM_DQ, rd_lo};
          end
        end
        WAIT: begin
          if (wait_zero) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready     = (state == DONE) || (state == IDLE && !req);
  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench with cycle-level reference model and SRAM array model
module tb_sram_controller;

  localparam int W = 3;
  localparam int DONE_PHASE = 3 + W;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
`ifdef SRAM_CTRL_ADDR_ERR_EN
  logic        addr_err;
  logic        f_unused_aerr;
`endif

  logic [31:0] f_unused_rdata;
  logic        f_ready;
  wire  [15:0] f_unused_dq;
  logic [17:0] f_unused_addr;
  logic [4:0]  f_unused_strobes;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
`ifdef SRAM_CTRL_ADDR_ERR_EN
    .addr_err  (addr_err),
`endif
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n)
  );

  sram_controller #(.WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_fast (
`ifdef SRAM_CTRL_ADDR_ERR_EN
    .addr_err  (f_unused_aerr),
`endif
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (f_unused_rdata),
    .ready     (f_ready),
    .SRAM_DQ   (f_unused_dq),
    .SRAM_ADDR (f_unused_addr),
    .SRAM_WE_N (f_unused_strobes[0]),
    .SRAM_OE_N (f_unused_strobes[1]),
    .SRAM_CE_N (f_unused_strobes[2]),
    .SRAM_UB_N (f_unused_strobes[3]),
    .SRAM_LB_N (f_unused_strobes[4])
  );

  // Async SRAM: drives the bus whenever not being written.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (rst) begin
      sram_mem[2] <= 16'h5678;
      sram_mem[3] <= 16'h1234;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_dq;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks cycles elapsed since the request and a word-level memory image.
  logic [31:0] ref_mem [int];
  logic [31:0] rd_exp;
  logic [31:0] m_data, m_off;
  logic [16:0] m_idx;
  logic        m_wr, m_err;
  bit          busy;
  int          phase;

  initial ref_mem[1] = 32'h12345678;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_rdata", read_data, 32'd0);
      busy   = 1'b0;
      rd_exp = 32'd0;
    end else if (!busy) begin
      check("idle_ready", 32'(ready), 32'(!(wr_en | rd_en)));
      check("idle_we_n", 32'(sram_we_n), 32'd1);
      check("idle_rdata", read_data, rd_exp);
      if (wr_en | rd_en) begin
        busy   = 1'b1;
        phase  = 1;
        m_wr   = wr_en;
        m_data = write_data;
        m_off  = address - 32'd1024;
        m_idx  = m_off[18:2];
`ifdef SRAM_CTRL_ADDR_ERR_EN
        m_err  = (address < 32'd1024) || (address >= 32'd1024 + 32'd524288);
`else
        m_err  = 1'b0;
`endif
      end
    end else begin
      check("busy_ready", 32'(ready), 32'(phase == DONE_PHASE));
      if (phase == 1 || phase == 2) begin
        check("acc_addr", 32'(sram_addr), 32'({m_idx, phase == 2}));
        check("acc_we_n", 32'(sram_we_n), 32'(!(m_wr && !m_err)));
        if (m_wr && !m_err)
          check("acc_dq", 32'(sram_dq), 32'(phase == 1 ? m_data[15:0] : m_data[31:16]));
      end else begin
        check("wait_we_n", 32'(sram_we_n), 32'd1);
      end
      if (phase == DONE_PHASE) begin
`ifdef SRAM_CTRL_ADDR_ERR_EN
        check("done_addr_err", 32'(addr_err), 32'(m_err));
`endif
        if (m_wr) begin
          if (!m_err) ref_mem[m_idx] = m_data;
          check("done_wr_rdata", read_data, rd_exp);
        end else if (m_err) begin
          rd_exp = 32'd0;
          check("done_err_rdata", read_data, rd_exp);
        end else if (ref_mem.exists(m_idx)) begin
          rd_exp = ref_mem[m_idx];
          check("done_rd_rdata", read_data, rd_exp);
        end
        busy = 1'b0;
      end
      phase++;
    end
  end

  logic [31:0] h_rdata [0:8];
  logic [17:0] h_addr  [0:8];
  logic [15:0] h_dq    [0:8];
  logic        h_ready [0:8];
  logic        h_fready[0:8];

  // Request is held only for its request cycle, then the inputs are scrambled.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr_en = w; rd_en = r; address = a; write_data = d;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      h_ready[k]  = ready;
      h_fready[k] = f_ready;
      h_addr[k]   = sram_addr;
      h_dq[k]     = sram_dq;
      h_rdata[k]  = read_data;
      @(posedge clk);
      #1;
      if (k == 0) begin
        wr_en = 1'b0; rd_en = 1'b0;
        address = $urandom; write_data = $urandom;
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check("wr_lo_addr", 32'(h_addr[1]), 32'd0);
    check("wr_lo_dq", 32'(h_dq[1]), 32'h0000BEEF);
    check("wr_hi_addr", 32'(h_addr[2]), 32'd1);
    check("wr_hi_dq", 32'(h_dq[2]), 32'h0000DEAD);
    for (int k = 0; k < 6; k++) check("wr_ready_low", 32'(h_ready[k]), 32'd0);
    check("wr_ready_c6", 32'(h_ready[6]), 32'd1);
    for (int k = 0; k < 3; k++) check("w0_ready_low", 32'(h_fready[k]), 32'd0);
    check("w0_ready_c3", 32'(h_fready[3]), 32'd1);

    access(1'b0, 1'b1, 32'd1028, 32'd0);
    check("rd_done_data", h_rdata[6], 32'h12345678);
    check("rd_done_ready", 32'(h_ready[6]), 32'd1);

    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    check("prio_addr", 32'(h_addr[1]), 32'd4);
    check("prio_dq", 32'(h_dq[1]), 32'h0000F00D);
    check("prio_rdata", h_rdata[6], 32'h12345678);

`ifndef SRAM_CTRL_ADDR_ERR_EN
    access(1'b0, 1'b1, 32'd1024 + 32'd524288 + 32'd8 + 32'd3, 32'd0);
    check("wrap_rdata", h_rdata[6], 32'hCAFEF00D);
`else
    access(1'b0, 1'b1, 32'd1032, 32'd0);
    check("rb_rdata", h_rdata[6], 32'hCAFEF00D);
    access(1'b0, 1'b1, 32'd512, 32'd0);
    check("err_rdata", h_rdata[6], 32'd0);
    check("err_we_n", 32'(sram_we_n), 32'd1);
`endif

    wr_en = 1'b1; address = 32'd1040; write_data = 32'hA5A55A5A;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    check("rst_mid_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_we_n", 32'(sram_we_n), 32'd1);
    check("post_rst_rdata", read_data, 32'd0);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1028, 32'd0);
    check("recover_rdata", h_rdata[6], 32'h12345678);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
